// File: rtl/ss_walker.sv
// Save-state walker: sweeps all 256 mapper save-state slots, saving them to a host buffer or restoring them from it.
// Latency: 4 cycles per slot; done pulses 1025 cycles after the accepted start, busy falls one cycle later.
// Backpressure: none; the walk runs at a fixed rate and can only be stopped by abort or rst.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, dir, abort        controller request (dir 0 = save, 1 = restore), abort of a running walk
//   busy, done               walk in progress, one-cycle completion pulse
//   buf_*                    host buffer side (registered read, one-cycle read latency)
//   ss_*                     mapper save-state side; mapper latches ss_wdat on the falling edge of ss_m2
//   chk                      running XOR checksum of transferred bytes (only when SS_WALK_CHK_EN is defined)
//
// Optional feature macro: SS_WALK_CHK_EN (adds the chk port and its accumulator).
module ss_walker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] buf_addr,
    output logic       buf_re,
    input  logic [7:0] buf_rdat,
    output logic       buf_we,
    output logic [7:0] buf_wdat,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    output logic       ss_m2,
    input  logic [7:0] ss_rdat
`ifdef SS_WALK_CHK_EN
    ,
    output logic [7:0] chk
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_DATA  = 3'd2,
        S_LATCH = 3'd3,
        S_FALL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_dir;
    logic [7:0] r_addr;
    logic       r_busy;
    logic       r_done;
    logic       r_buf_re;
    logic       r_buf_we;
    logic [7:0] r_buf_wdat;
    logic       r_ss_act;
    logic       r_ss_we;
    logic [7:0] r_ss_wdat;
    logic       r_ss_m2;
`ifdef SS_WALK_CHK_EN
    logic [7:0] r_chk;
`endif

    // Every output is a register loaded with the value it must carry in the
    // state being entered, so the outputs change only on clock edges (and on rst).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_addr     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_buf_re   <= 1'b0;
            r_buf_we   <= 1'b0;
            r_buf_wdat <= 8'h00;
            r_ss_act   <= 1'b0;
            r_ss_we    <= 1'b0;
            r_ss_wdat  <= 8'h00;
            r_ss_m2    <= 1'b0;
`ifdef SS_WALK_CHK_EN
            r_chk      <= 8'h00;
`endif
        end else begin
            // Single-cycle strobes default low; states below raise them as needed.
            r_done   <= 1'b0;
            r_buf_re <= 1'b0;
            r_buf_we <= 1'b0;
            r_ss_we  <= 1'b0;
            r_ss_m2  <= 1'b0;

            if (r_state != S_IDLE && abort) begin
                // Abort wins over every other transition, including the
                // checksum update at the end of FALL.
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_ss_act <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state  <= S_SETUP;
                            r_dir    <= dir;
                            r_addr   <= 8'h00;
                            r_busy   <= 1'b1;
                            r_ss_act <= 1'b1;
                            r_buf_re <= dir;
`ifdef SS_WALK_CHK_EN
                            r_chk    <= 8'h00;
`endif
                        end
                    end
                    S_SETUP: begin
                        r_state <= S_DATA;
                        r_ss_m2 <= 1'b1;
                    end
                    S_DATA: begin
                        r_state <= S_LATCH;
                        r_ss_m2 <= 1'b1;
                        r_ss_we <= r_dir;
                        // Buffer data requested in SETUP is valid during DATA.
                        if (r_dir) begin
                            r_ss_wdat <= buf_rdat;
                        end
                    end
                    S_LATCH: begin
                        r_state  <= S_FALL;
                        // ss_we is held through FALL so the mapper sees it at the m2 falling edge.
                        r_ss_we  <= r_dir;
                        r_buf_we <= !r_dir;
                        if (!r_dir) begin
                            r_buf_wdat <= ss_rdat;
                        end
                    end
                    S_FALL: begin
`ifdef SS_WALK_CHK_EN
                        r_chk <= r_chk ^ (r_dir ? r_ss_wdat : r_buf_wdat);
`endif
                        if (r_addr == 8'hFF) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_ss_act <= 1'b0;
                        end else begin
                            r_state  <= S_SETUP;
                            r_addr   <= r_addr + 8'd1;
                            r_buf_re <= r_dir;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_ss_act <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign buf_addr = r_addr;
    assign buf_re   = r_buf_re;
    assign buf_we   = r_buf_we;
    assign buf_wdat = r_buf_wdat;
    assign ss_act   = r_ss_act;
    assign ss_we    = r_ss_we;
    assign ss_addr  = r_addr;
    assign ss_wdat  = r_ss_wdat;
    assign ss_m2    = r_ss_m2;
`ifdef SS_WALK_CHK_EN
    assign chk      = r_chk;
`endif

endmodule

// File: tb/tb_ss_walker.sv
// Bench for ss_walker: buffer and mapper models, a timeline reference model and a per-cycle compare.
// Latency: the reference model places slot k in cycles 4k..4k+3 after the accepted start, DONE at offset 1024.
// Backpressure: none; stimulus is driven on falling clock edges.
module tb_ss_walker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dir;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] buf_addr;
    logic       buf_re;
    logic [7:0] buf_rdat;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic       ss_m2;
    logic [7:0] ss_rdat;
`ifdef SS_WALK_CHK_EN
    logic [7:0] chk;
`endif

    ss_walker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .buf_addr (buf_addr),
        .buf_re   (buf_re),
        .buf_rdat (buf_rdat),
        .buf_we   (buf_we),
        .buf_wdat (buf_wdat),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_m2    (ss_m2),
        .ss_rdat  (ss_rdat)
`ifdef SS_WALK_CHK_EN
        ,
        .chk      (chk)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: host buffer and mapper ----------------
    logic [7:0] buf_mem [256];
    logic [7:0] map_mem [256];
    logic       last_m2 = 1'b0;
    int         n_done  = 0;
    int         n_bufwe = 0;

    assign ss_rdat = map_mem[ss_addr];

    always @(posedge clk) begin
        if (buf_re) buf_rdat <= buf_mem[buf_addr];
        if (buf_we) buf_mem[buf_addr] <= buf_wdat;
    end

    task automatic fill(input bit is_map, input int mode);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            case (mode)
                0: v = 8'(i) ^ 8'h5A;
                1: v = ~8'(i);
                2: v = 8'($urandom);
                3: v = 8'hFF;
                4: v = 8'(i);
                default: v = 8'h00;
            endcase
            if (is_map) map_mem[i] = v;
            else        buf_mem[i] = v;
        end
    endtask

    // ---------------- reference model: position in the walk timeline ----------------
    bit         m_active = 1'b0;
    bit         m_dir    = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_addr   = 8'h00;
    logic [7:0] m_chk    = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_addr   = 8'h00;
            m_chk    = 8'h00;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1'b1;
                m_dir    = dir;
                m_t      = 0;
                m_addr   = 8'h00;
                m_chk    = 8'h00;
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else begin
            if (m_t < 1024 && (m_t % 4) == 3)
                m_chk ^= m_dir ? buf_mem[m_t / 4] : map_mem[m_t / 4];
            m_t++;
            if (m_t > 1024) m_active = 1'b0;
            else            m_addr = (m_t >= 1024) ? 8'hFF : 8'(m_t / 4);
        end
    end

    // ---------------- per-cycle compare and mapper falling-edge latch ----------------
    always @(negedge clk) begin
        if (!rst) begin
            bit in_slot;
            int ph;
            int sl;
            in_slot = m_active && (m_t < 1024);
            ph = m_t % 4;
            sl = (m_t < 1024) ? m_t / 4 : 255;
            check("busy",     busy,     m_active);
            check("done",     done,     m_active && m_t == 1024);
            check("ss_act",   ss_act,   in_slot);
            check("ss_m2",    ss_m2,    in_slot && (ph == 1 || ph == 2));
            check("ss_we",    ss_we,    in_slot && m_dir && ph >= 2);
            check("buf_re",   buf_re,   in_slot && m_dir && ph == 0);
            check("buf_we",   buf_we,   in_slot && !m_dir && ph == 3);
            check("ss_addr",  ss_addr,  m_addr);
            check("buf_addr", buf_addr, m_addr);
            if (in_slot && m_dir && ph >= 2)
                check("ss_wdat", ss_wdat, buf_mem[sl]);
            if (in_slot && !m_dir && ph == 3)
                check("buf_wdat", buf_wdat, map_mem[sl]);
`ifdef SS_WALK_CHK_EN
            check("chk", chk, m_chk);
`endif
            if (done)   n_done++;
            if (buf_we) n_bufwe++;
            // Mapper latches on the falling edge of ss_m2 while ss_we is high.
            if (last_m2 && !ss_m2 && ss_we) map_mem[ss_addr] = ss_wdat;
            last_m2 = ss_m2;
        end else begin
            last_m2 = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_walk(input logic d, input int restart_at, output int lat);
        dir   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 1200) begin
            @(negedge clk);
            lat++;
            start = (lat == restart_at);
        end
        start = 1'b0;
        check("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic all_zero(input string name);
        check(name, {busy, done, buf_addr, buf_re, buf_we, buf_wdat, ss_act, ss_we, ss_addr, ss_wdat, ss_m2}, 64'h0);
`ifdef SS_WALK_CHK_EN
        check({name, "_chk"}, chk, 8'h00);
`endif
    endtask

    initial begin
        int lat;
        int cnt;
        int err;
        int d0;
        rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
        fill(1'b1, 5);
        fill(1'b0, 5);
        repeat (2) @(negedge clk);
        all_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Save: mapper returns addr^0x5A.
        fill(1'b1, 0);
        fill(1'b0, 2);
        n_bufwe = 0;
        run_walk(1'b0, 0, lat);
        check("save_latency", lat, 1025);
        check("save_bufwe_count", n_bufwe, 256);
        err = 0;
        for (int i = 0; i < 256; i++) if (buf_mem[i] !== (8'(i) ^ 8'h5A)) err++;
        check("save_buffer_contents", err, 0);

        // Restore: buffer = ~addr, with a stray start while busy.
        fill(1'b0, 1);
        fill(1'b1, 2);
        d0 = n_done;
        run_walk(1'b1, 300, lat);
        check("restore_latency", lat, 1025);
        check("restore_done_once", n_done - d0, 1);
        err = 0;
        for (int i = 0; i < 256; i++) if (map_mem[i] !== ~8'(i)) err++;
        check("restore_mapper_contents", err, 0);
        repeat (3) @(negedge clk);

        // Abort during LATCH of slot 0x40 in restore.
        fill(1'b0, 2);
        buf_mem[8'h40] = 8'hA5;
        fill(1'b1, 5);
        d0 = n_done;
        dir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(ss_m2 && ss_we && ss_addr == 8'h40) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_reached_latch40", cnt < 2000, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, done, ss_act, ss_we, ss_m2, buf_we, buf_re}, 7'b0);
        repeat (4) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        err = 0;
        for (int i = 0; i < 8'h40; i++) if (map_mem[i] !== buf_mem[i]) err++;
        check("abort_slots_written", err, 0);
        check("abort_slot40_untouched", map_mem[8'h40], 8'h00);

        // start and abort together in IDLE: stay idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-walk during slot 0x80.
        fill(1'b1, 2);
        dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (ss_addr != 8'h80 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_reached_slot80", cnt < 2000, 1'b1);
        d0 = n_done;
        #2 rst = 1'b1;
        #1 all_zero("async_reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", n_done - d0, 0);
        fill(1'b1, 0);
        run_walk(1'b0, 0, lat);
        check("post_rst_latency", lat, 1025);
        err = 0;
        for (int i = 0; i < 256; i++) if (buf_mem[i] !== (8'(i) ^ 8'h5A)) err++;
        check("post_rst_buffer", err, 0);

        // Random walks with random abort points.
        for (int k = 0; k < 4; k++) begin
            fill(1'b1, 2);
            fill(1'b0, 2);
            dir = 1'($urandom); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(1, 1100)) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (3) @(negedge clk);
            check("rand_abort_idle", busy, 1'b0);
        end

`ifdef SS_WALK_CHK_EN
        fill(1'b1, 3);
        run_walk(1'b0, 0, lat);
        check("chk_save_all_ff", chk, 8'h00);
        fill(1'b1, 2);
        buf_mem[0] = 8'h00;
        run_walk(1'b0, 0, lat);
        fill(1'b0, 4);
        run_walk(1'b1, 0, lat);
        check("chk_restore_addr", chk, 8'h00);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_walker.md
# ss_walker

Save-state walker for the mapper save-state port. It drives the mapper side's `ss_act`/`ss_we`/`ss_addr`/write-data/strobe lanes and reads `ss_rdat`, sweeping all 256 register slots. In save mode it reads each slot back into a 256-byte host buffer; in restore mode it writes the buffer contents back into each slot. It sits between the system controller (start/abort/busy/done) and the active mapper's save-state inputs, and is the initiator of the save-state protocol that every mapper responds to.

## Interface

Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `dir`  in  1  direction, sampled with `start`: 0 = save (mapper to buffer), 1 = restore (buffer to mapper).
- `abort`  in  1  terminate the current walk.
- `busy`  out  1  high while a walk is in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `buf_addr`  out  8  buffer address; equals `ss_addr`.
- `buf_re`  out  1  buffer read request; read data is valid one cycle later.
- `buf_rdat`  in  8  buffer read data.
- `buf_we`  out  1  buffer write strobe.
- `buf_wdat`  out  8  buffer write data.
- `ss_act`  out  1  save-state access active; mapper ignores CPU register writes while high.
- `ss_we`  out  1  save-state write enable.
- `ss_addr`  out  8  save-state slot address.
- `ss_wdat`  out  8  data presented on the mapper's `cpu_dat` lane during restore.
- `ss_m2`  out  1  mapper strobe; the mapper latches on its falling edge.
- `ss_rdat`  in  8  mapper slot readback; combinational from `ss_addr`.
- `chk`  out  8  running checksum; present only with `SS_WALK_CHK_EN`.

## Operation

- States: IDLE, SETUP, DATA, LATCH, FALL, DONE.
- Each slot takes 4 cycles: SETUP, DATA, LATCH, FALL.
- IDLE
  - `start=1` with `abort=0`: latch `dir`, set addr to 0, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP
  - `ss_act=1`; `ss_addr` and `buf_addr` hold the current addr.
  - `buf_re=1` only in restore mode.
- DATA
  - `ss_m2=1`.
  - Restore: capture `buf_rdat` into `ss_wdat` at the end of DATA.
- LATCH
  - `ss_m2=1`.
  - Restore: `ss_we=1`.
  - Save: capture `ss_rdat` into `buf_wdat` at the end of LATCH.
- FALL
  - `ss_m2=0`, producing the falling edge at the start of this cycle.
  - Restore: `ss_we` stays 1 for the whole cycle.
  - Save: `buf_we=1`.
  - At the end of FALL: if addr==255 go to DONE, else addr+1 and go to SETUP.
- DONE
  - `done=1` and `ss_act=0` for one cycle, then IDLE.
- `busy` is 1 in SETUP, DATA, LATCH, FALL and DONE.
- `start` while busy is ignored.
- `abort`
  - Honoured in any non-IDLE state.
  - Next state is IDLE with `ss_act`, `ss_we`, `ss_m2`, `buf_we`, `buf_re` all 0.
  - No `done` pulse.
  - Mapper slots already written keep their new values.
- `start` and `abort` in the same IDLE cycle: stay in IDLE.
- The address counter is 8 bits and never wraps: the walk ends at 255.
- Slots that the mapper does not implement are still walked. Their readback (typically 0xFF) is stored as-is.

## Timing

- Reset values: every output is 0 (`ss_addr`=0x00, `ss_wdat`=0x00, `chk`=0x00); state is IDLE.
- Reset asserted mid-walk: outputs go to reset values immediately (asynchronous); no `done`.
- `start` sampled at edge N: SETUP for slot 0 in cycle N+1.
  - `busy` rises in cycle N+1.
  - Slot k occupies cycles N+1+4k through N+4+4k.
  - `done` occurs in cycle N+1025; `busy` falls in cycle N+1026.
- Restore: `ss_wdat` is stable from the start of LATCH through the end of FALL, covering the mapper's falling-edge sample.
- `ss_addr` is stable for all 4 cycles of its slot.
- `ss_act` is continuous from SETUP of slot 0 through FALL of slot 255.

## Configuration

- `SS_WALK_CHK_EN` defined:
  - `chk` clears to 0 on each accepted `start`.
  - It is XOR-accumulated with every transferred byte: the `buf_wdat` value in save FALL, and the `ss_wdat` value in restore FALL.
  - `chk` is stable from DONE until the next `start`.
- `SS_WALK_CHK_EN` undefined: the `chk` port and its logic are absent.

## Test plan

- Save with a mapper model returning `ss_rdat`=addr^0x5A:
  - expect 256 `buf_we` pulses with `buf_wdat`=addr^0x5A;
  - `done` exactly 1025 cycles after `start`.
- Restore with buffer contents = ~addr:
  - the model latches `ss_wdat` on the `ss_m2` falling edge with `ss_we`=1 and records ~addr in every slot 0..255;
  - no writes occur while `ss_m2` is high.
- `abort` asserted during LATCH of slot 0x40:
  - next cycle is IDLE with all strobes 0 and no `done`;
  - slots 0..0x3F are written, 0x40 is not.
- `start` pulsed again while busy and in the same cycle as `abort` in IDLE: both are ignored, and the walk completes or stays idle unchanged.
- `rst` pulsed during slot 0x80: all outputs read 0 within the same cycle; a subsequent `start` walks from slot 0.
- With `SS_WALK_CHK_EN`, saving an all-0xFF readback gives `chk`=0x00; restoring buffer contents = addr gives `chk`=0x00 (XOR of 0..255).
